line_port_arbiter: RTL and testbench
====================================

# line_port_arbiter

Shares the single 64-byte-line memory read port between the instruction-fetch unit and the data-side load unit. Each requester uses the same one-cycle enable / address / done / 512-bit line handshake the fetch unit already drives toward the I-cache. The block captures requests, arbitrates round-robin, sequences one outstanding memory transaction at a time and routes the returned line to its owner. An optional one-line reuse buffer answers repeat requests to the last line without a memory access.

## Interface
- No parameters; line size fixed at 64 bytes, address width 64.
- clk  in  1  sole clock, all state updates on posedge
- reset_n  in  1  asynchronous active-low reset
- i_enable  in  1  instruction request pulse (one cycle)
- i_addr  in  64  instruction request byte address, sampled with i_enable
- i_data  out  512  line returned to instruction side, held until next i_done
- i_done  out  1  one-cycle completion pulse to instruction side
- d_enable, d_addr, d_data, d_done  same as the i_* ports, data side
- mem_enable  out  1  one-cycle memory request pulse
- mem_addr  out  64  line-aligned address, valid with mem_enable, held while BUSY
- mem_data  in  512  returned line, valid with mem_done
- mem_done  in  1  one-cycle memory completion pulse
- inv  in  1  invalidates the reuse buffer; ignored without LINE_ARB_REUSE_EN
- proto_err  out  1  sticky; set when a requester pulses enable while its previous request is incomplete

## Operation
- Per requester, one slot: {pend, addr[63:6]}. On enable with slot free, set pend and store addr & ~63. On enable with slot busy (pending or in flight), drop the request and set proto_err; the slot is unchanged.
- FSM states: IDLE, BUSY.
  - IDLE, at least one pend: pick the winner, register mem_enable=1 and mem_addr=slot addr, record owner, clear the winner's pend, go BUSY.
  - BUSY: mem_enable=0 after its single cycle. On mem_done: copy mem_data to owner's *_data, pulse owner's *_done next cycle, return to IDLE.
  - mem_done in IDLE is ignored.
- Round-robin: with both pending, grant the side not in last_grant. With one pending, grant it. last_grant updates at each grant.
- A slot counts as busy from capture until its done pulse.
- mem_addr[5:0] always 0. *_data is never altered except by that side's completion.

## Timing
- Reset values: i_done=d_done=mem_enable=proto_err=0; i_data=d_data=mem_addr=0; pend=0; state IDLE; last_grant=data, so the first tie goes to instruction; reuse buffer invalid.
- Memory path with idle port: enable at edge N is captured; mem_enable is high in cycle N+1. mem_done sampled at edge M gives *_done high in cycle M+1. Minimum turnaround is 2 cycles plus memory latency.
- Back-to-back: the FSM is IDLE in cycle M+1; the next grant's mem_enable is high in cycle M+2.
- An enable captured on the same edge as the other side's mem_done is eligible in IDLE at the next edge.
- i_done and d_done are never simultaneous from the memory path. A reuse hit may coincide with the other side's memory done.
- Reset mid-transaction: all state cleared immediately. The memory port shares reset_n, so an aborted transaction produces no mem_done.

## Configuration
- LINE_ARB_REUSE_EN defined:
  - Adds buf_valid, buf_addr[63:6] and buf_line[511:0], loaded on every mem_done.
  - An enable whose line address matches a valid buffer completes without touching the slot or the memory port: *_data=buf_line and *_done high in the cycle after enable.
  - inv clears buf_valid. inv on the same edge as mem_done leaves the buffer invalid. inv on the same edge as a matching enable forces a memory request.
- LINE_ARB_REUSE_EN undefined: no buffer; inv ignored; every request goes to memory.

## Test plan
- Single fetch: i_enable with i_addr=0x1047, memory latency 3 -> mem_enable one cycle with mem_addr=0x1040; i_done one cycle after mem_done; i_data equals mem_data.
- Simultaneous i_enable and d_enable after reset -> instruction granted first, data mem_enable two cycles after instruction's mem_done; next tie goes to data.
- Second i_enable before i_done -> proto_err=1 and stays set; only one mem_enable issued for the instruction side.
- Assert reset_n low while BUSY -> all outputs 0 immediately; a later request proceeds normally from IDLE.
- REUSE_EN: fetch 0x2000, then d_enable at 0x2010 -> d_done next cycle with the same line, no mem_enable; after an inv pulse, the same request goes to memory.
- REUSE_EN off: repeat of 0x2000 -> second mem_enable issued.

Source files
------------

// File: rtl/line_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// line_port_arbiter_if
// One-cycle enable / address / done / 512-bit line handshake. The same bundle
// serves requester-to-arbiter links (arbiter uses slave) and the
// arbiter-to-memory link (arbiter uses master).
// Revision: 1.0 - initial release
// ============================================================================
interface line_port_arbiter_if;
  logic         enable;  // one-cycle request pulse
  logic [63:0]  addr;    // byte address, valid with enable
  logic [511:0] data;    // returned line
  logic         done;    // one-cycle completion pulse

  // Side that issues requests and receives lines
  modport master (output enable, output addr, input data, input done);
  // Side that accepts requests and returns lines
  modport slave  (input enable, input addr, output data, output done);
endinterface
`default_nettype wire

// File: rtl/line_port_arbiter.sv
`default_nettype none
// ============================================================================
// line_port_arbiter
// Shares one 64-byte-line memory read port between the instruction-fetch side
// and the data-load side. One slot per requester, round-robin grant, a single
// outstanding memory transaction, line routed back to its owner.
// Optional feature macro: LINE_ARB_REUSE_EN (one-line reuse buffer that
// answers repeat requests to the last returned line without a memory access).
// Revision: 1.0 - initial release
// ============================================================================
module line_port_arbiter (
  input  wire                  clk,
  input  wire                  reset_n,
  line_port_arbiter_if.slave   i_port,
  line_port_arbiter_if.slave   d_port,
  line_port_arbiter_if.master  mem_port,
  input  wire                  inv,
  output logic                 proto_err
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
  typedef enum logic [0:0] {SIDE_I = 1'b0, SIDE_D = 1'b1} side_t;

  // Registered state
  state_t       state_q,      state_d;
  side_t        owner_q,      owner_d;
  side_t        last_grant_q, last_grant_d;
  logic         i_pend_q,     i_pend_d;
  logic [57:0]  i_slot_q,     i_slot_d;
  logic         d_pend_q,     d_pend_d;
  logic [57:0]  d_slot_q,     d_slot_d;
  logic         mem_enable_q, mem_enable_d;
  logic [57:0]  mem_addr_q,   mem_addr_d;
  logic [511:0] i_data_q,     i_data_d;
  logic         i_done_q,     i_done_d;
  logic [511:0] d_data_q,     d_data_d;
  logic         d_done_q,     d_done_d;
  logic         proto_err_q,  proto_err_d;

  // Request classification
  logic  i_busy, d_busy;   // slot pending or in flight
  logic  i_hit,  d_hit;    // served from reuse buffer
  logic  i_new,  d_new;    // fresh request accepted into arbitration
  logic  i_cand, d_cand;   // eligible for grant this cycle
  side_t win;

  // Low address bits are never used: every request is for a whole line
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_port.addr[5:0], d_port.addr[5:0]};

`ifdef LINE_ARB_REUSE_EN
  logic         buf_valid_q, buf_valid_d;
  logic [57:0]  buf_addr_q,  buf_addr_d;
  logic [511:0] buf_line_q,  buf_line_d;

  // A hit needs a free slot and a valid, un-invalidated matching line
  always_comb begin
    i_hit = i_port.enable && !i_busy && buf_valid_q && !inv &&
            (buf_addr_q == i_port.addr[63:6]);
    d_hit = d_port.enable && !d_busy && buf_valid_q && !inv &&
            (buf_addr_q == d_port.addr[63:6]);
  end
`else
  logic unused_inv;
  assign unused_inv = inv;

  // Without the buffer every request goes to memory
  always_comb begin
    i_hit = 1'b0;
    d_hit = 1'b0;
  end
`endif

  // Slot occupancy and grant eligibility; an idle port may grant a fresh
  // enable directly so the memory request leaves the cycle after enable
  always_comb begin
    i_busy = i_pend_q || ((state_q == S_BUSY) && (owner_q == SIDE_I));
    d_busy = d_pend_q || ((state_q == S_BUSY) && (owner_q == SIDE_D));
    i_new  = i_port.enable && !i_busy && !i_hit;
    d_new  = d_port.enable && !d_busy && !d_hit;
    i_cand = i_pend_q || i_new;
    d_cand = d_pend_q || d_new;
  end

  // Capture, arbitration and transaction sequencing
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    i_pend_d     = i_pend_q;
    i_slot_d     = i_slot_q;
    d_pend_d     = d_pend_q;
    d_slot_d     = d_slot_q;
    mem_enable_d = 1'b0;
    mem_addr_d   = mem_addr_q;
    i_data_d     = i_data_q;
    i_done_d     = 1'b0;
    d_data_d     = d_data_q;
    d_done_d     = 1'b0;
    proto_err_d  = proto_err_q;
    win          = SIDE_I;
`ifdef LINE_ARB_REUSE_EN
    buf_valid_d  = buf_valid_q;
    buf_addr_d   = buf_addr_q;
    buf_line_d   = buf_line_q;
`endif

    // Enable on an occupied slot is a protocol error; the request is dropped
    if (i_port.enable && i_busy) proto_err_d = 1'b1;
    if (d_port.enable && d_busy) proto_err_d = 1'b1;

    // Reuse hits complete next cycle without touching slot or memory
    if (i_hit) begin
      i_done_d = 1'b1;
`ifdef LINE_ARB_REUSE_EN
      i_data_d = buf_line_q;
`endif
    end
    if (d_hit) begin
      d_done_d = 1'b1;
`ifdef LINE_ARB_REUSE_EN
      d_data_d = buf_line_q;
`endif
    end

    // Fresh requests park in their slot; a winner's pend is cleared below
    if (i_new) begin
      i_pend_d = 1'b1;
      i_slot_d = i_port.addr[63:6];
    end
    if (d_new) begin
      d_pend_d = 1'b1;
      d_slot_d = d_port.addr[63:6];
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_cand || d_cand) begin
          if (i_cand && d_cand)
            win = (last_grant_q == SIDE_D) ? SIDE_I : SIDE_D;
          else
            win = i_cand ? SIDE_I : SIDE_D;
          mem_enable_d = 1'b1;
          owner_d      = win;
          last_grant_d = win;
          state_d      = S_BUSY;
          if (win == SIDE_I) begin
            mem_addr_d = i_pend_q ? i_slot_q : i_port.addr[63:6];
            i_pend_d   = 1'b0;
          end else begin
            mem_addr_d = d_pend_q ? d_slot_q : d_port.addr[63:6];
            d_pend_d   = 1'b0;
          end
        end
      end
      S_BUSY: begin
        if (mem_port.done) begin
          state_d = S_IDLE;
          if (owner_q == SIDE_I) begin
            i_data_d = mem_port.data;
            i_done_d = 1'b1;
          end else begin
            d_data_d = mem_port.data;
            d_done_d = 1'b1;
          end
`ifdef LINE_ARB_REUSE_EN
          buf_valid_d = 1'b1;
          buf_addr_d  = mem_addr_q;
          buf_line_d  = mem_port.data;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef LINE_ARB_REUSE_EN
    // Invalidate wins over a same-edge load
    if (inv) buf_valid_d = 1'b0;
`endif
  end

  // State register; reset aborts any transaction immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= SIDE_I;
      last_grant_q <= SIDE_D;
      i_pend_q     <= 1'b0;
      i_slot_q     <= '0;
      d_pend_q     <= 1'b0;
      d_slot_q     <= '0;
      mem_enable_q <= 1'b0;
      mem_addr_q   <= '0;
      i_data_q     <= '0;
      i_done_q     <= 1'b0;
      d_data_q     <= '0;
      d_done_q     <= 1'b0;
      proto_err_q  <= 1'b0;
`ifdef LINE_ARB_REUSE_EN
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      buf_line_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      i_pend_q     <= i_pend_d;
      i_slot_q     <= i_slot_d;
      d_pend_q     <= d_pend_d;
      d_slot_q     <= d_slot_d;
      mem_enable_q <= mem_enable_d;
      mem_addr_q   <= mem_addr_d;
      i_data_q     <= i_data_d;
      i_done_q     <= i_done_d;
      d_data_q     <= d_data_d;
      d_done_q     <= d_done_d;
      proto_err_q  <= proto_err_d;
`ifdef LINE_ARB_REUSE_EN
      buf_valid_q  <= buf_valid_d;
      buf_addr_q   <= buf_addr_d;
      buf_line_q   <= buf_line_d;
`endif
    end
  end

  // Outputs come straight from registers
  assign i_port.data     = i_data_q;
  assign i_port.done     = i_done_q;
  assign d_port.data     = d_data_q;
  assign d_port.done     = d_done_q;
  assign mem_port.enable = mem_enable_q;
  assign mem_port.addr   = {mem_addr_q, 6'b00_0000};
  assign proto_err       = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_line_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_line_port_arbiter
// Directed, table-driven bench for line_port_arbiter plus hand-written
// sequences for asynchronous reset and the reuse-buffer behaviour.
// Revision: 1.0 - initial release
// ============================================================================
module tb_line_port_arbiter;

  logic clk;
  logic reset_n;
  logic inv;
  logic proto_err;

  line_port_arbiter_if ip ();
  line_port_arbiter_if dp ();
  line_port_arbiter_if mp ();

  line_port_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_port    (ip),
    .d_port    (dp),
    .mem_port  (mp),
    .inv       (inv),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        nm;
    logic         rst;
    logic         ie;
    logic [63:0]  ia;
    logic         de;
    logic [63:0]  da;
    logic         md;
    logic [511:0] mdv;
    logic         iv;
    logic         e_me;
    logic [63:0]  e_ma;
    logic         e_id;
    logic         e_dd;
    logic         e_pe;
    logic [511:0] e_idat;
    logic [511:0] e_ddat;
  } vec_t;

  vec_t rows[$];

  function automatic logic [511:0] mk(input logic [31:0] n);
    return {16{n}};
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic rst, input logic ie, input logic [63:0] ia,
                     input logic de, input logic [63:0] da, input logic md,
                     input logic [511:0] mdv, input logic iv, input logic e_me,
                     input logic [63:0] e_ma, input logic e_id, input logic e_dd,
                     input logic e_pe, input logic [511:0] e_idat, input logic [511:0] e_ddat);
    rows.push_back('{nm, rst, ie, ia, de, da, md, mdv, iv, e_me, e_ma, e_id, e_dd, e_pe,
                     e_idat, e_ddat});
  endtask

  // Drive one cycle of inputs at negedge, then sample #1 after the posedge
  task automatic drive(input logic rst, input logic ie, input logic [63:0] ia,
                       input logic de, input logic [63:0] da, input logic md,
                       input logic [511:0] mdv, input logic iv);
    @(negedge clk);
    reset_n   = !rst;
    ip.enable = ie;
    ip.addr   = ia;
    dp.enable = de;
    dp.addr   = da;
    mp.done   = md;
    mp.data   = md ? mdv : mk(32'hBAD0_BAD0);
    inv       = iv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic e_me, input logic [63:0] e_ma,
                         input logic e_id, input logic e_dd, input logic e_pe,
                         input logic [511:0] e_idat, input logic [511:0] e_ddat);
    chk({nm, ".mem_enable"}, 512'(mp.enable), 512'(e_me));
    chk({nm, ".mem_addr"},   512'(mp.addr),   512'(e_ma));
    chk({nm, ".i_done"},     512'(ip.done),   512'(e_id));
    chk({nm, ".d_done"},     512'(dp.done),   512'(e_dd));
    chk({nm, ".proto_err"},  512'(proto_err), 512'(e_pe));
    chk({nm, ".i_data"},     ip.data,         e_idat);
    chk({nm, ".d_data"},     dp.data,         e_ddat);
  endtask

  localparam logic [511:0] Z = '0;

  initial begin
    logic [511:0] l1, l2, l3, l4, l5, l6, l7, l8, l9, lx, l12, l13, l14;
    l1 = mk(32'h1111_0001); l2 = mk(32'h2222_0002); l3 = mk(32'h3333_0003);
    l4 = mk(32'h4444_0004); l5 = mk(32'h5555_0005); l6 = mk(32'h6666_0006);
    l7 = mk(32'h7777_0007); l8 = mk(32'h8888_0008); l9 = mk(32'h9999_0009);
    lx = mk(32'hDEAD_BEEF); l12 = mk(32'hC0DE_000C); l13 = mk(32'hCAFE_000D);
    l14 = mk(32'hF00D_000E);

    //   name                 rst ie ia        de da        md line inv  me ma        id dd pe i_data d_data
    add("fetch_req",          0, 1, 'h1047, 0, 0,       0, Z,  0,   1, 'h1040, 0, 0, 0, Z,  Z);
    add("fetch_wait1",        0, 0, 0,      0, 0,       0, Z,  0,   0, 'h1040, 0, 0, 0, Z,  Z);
    add("fetch_wait2",        0, 0, 0,      0, 0,       0, Z,  0,   0, 'h1040, 0, 0, 0, Z,  Z);
    add("fetch_done",         0, 0, 0,      0, 0,       1, l1, 0,   0, 'h1040, 1, 0, 0, l1, Z);
    add("fetch_hold",         0, 0, 0,      0, 0,       0, Z,  0,   0, 'h1040, 0, 0, 0, l1, Z);
    add("reset_row",          1, 0, 0,      0, 0,       0, Z,  0,   0, 0,      0, 0, 0, Z,  Z);
    add("tie_grant_i",        0, 1, 'h3000, 1, 'h4080,  0, Z,  0,   1, 'h3000, 0, 0, 0, Z,  Z);
    add("tie_wait",           0, 0, 0,      0, 0,       0, Z,  0,   0, 'h3000, 0, 0, 0, Z,  Z);
    add("tie_i_done",         0, 0, 0,      0, 0,       1, l2, 0,   0, 'h3000, 1, 0, 0, l2, Z);
    add("tie_d_grant",        0, 0, 0,      0, 0,       0, Z,  0,   1, 'h4080, 0, 0, 0, l2, Z);
    add("tie_d_done",         0, 0, 0,      0, 0,       1, l3, 0,   0, 'h4080, 0, 1, 0, l2, l3);
    add("solo_i",             0, 1, 'h5000, 0, 0,       0, Z,  0,   1, 'h5000, 0, 0, 0, l2, l3);
    add("solo_i_done",        0, 0, 0,      0, 0,       1, l4, 0,   0, 'h5000, 1, 0, 0, l4, l3);
    add("tie_grant_d",        0, 1, 'h7000, 1, 'h8000,  0, Z,  0,   1, 'h8000, 0, 0, 0, l4, l3);
    add("tie_d_done2",        0, 0, 0,      0, 0,       1, l5, 0,   0, 'h8000, 0, 1, 0, l4, l5);
    add("pend_i_grant",       0, 0, 0,      0, 0,       0, Z,  0,   1, 'h7000, 0, 0, 0, l4, l5);
    add("pend_i_done",        0, 0, 0,      0, 0,       1, l6, 0,   0, 'h7000, 1, 0, 0, l6, l5);
    add("idle_done_ignored",  0, 0, 0,      0, 0,       1, lx, 0,   0, 'h7000, 0, 0, 0, l6, l5);
    add("req_9000",           0, 1, 'h9000, 0, 0,       0, Z,  0,   1, 'h9000, 0, 0, 0, l6, l5);
    add("busy_9000",          0, 0, 0,      0, 0,       0, Z,  0,   0, 'h9000, 0, 0, 0, l6, l5);
    add("done_and_d_req",     0, 0, 0,      1, 'hA000,  1, l7, 0,   0, 'h9000, 1, 0, 0, l7, l5);
    add("d_after_done",       0, 0, 0,      0, 0,       0, Z,  0,   1, 'hA000, 0, 0, 0, l7, l5);
    add("d_done_A000",        0, 0, 0,      0, 0,       1, l8, 0,   0, 'hA000, 0, 1, 0, l7, l8);
    add("req_B000",           0, 1, 'hB000, 0, 0,       0, Z,  0,   1, 'hB000, 0, 0, 0, l7, l8);
    add("proto_dup",          0, 1, 'hC000, 0, 0,       0, Z,  0,   0, 'hB000, 0, 0, 1, l7, l8);
    add("proto_done",         0, 0, 0,      0, 0,       1, l9, 0,   0, 'hB000, 1, 0, 1, l9, l8);
    add("proto_no_regrant",   0, 0, 0,      0, 0,       0, Z,  0,   0, 'hB000, 0, 0, 1, l9, l8);

    // Reset state
    reset_n = 1'b0; inv = 1'b0;
    ip.enable = 1'b0; ip.addr = '0; dp.enable = 1'b0; dp.addr = '0;
    mp.done = 1'b0; mp.data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, Z, Z);

    // Table-driven cycle vectors
    foreach (rows[k]) begin
      drive(rows[k].rst, rows[k].ie, rows[k].ia, rows[k].de, rows[k].da,
            rows[k].md, rows[k].mdv, rows[k].iv);
      chk_all(rows[k].nm, rows[k].e_me, rows[k].e_ma, rows[k].e_id, rows[k].e_dd,
              rows[k].e_pe, rows[k].e_idat, rows[k].e_ddat);
    end

    // Asynchronous reset while a transaction is in flight
    drive(0, 1, 'hD000, 0, 0, 0, Z, 0);
    chk("rst_pre.mem_enable", 512'(mp.enable), 512'(1'b1));
    chk("rst_pre.mem_addr",   512'(mp.addr),   512'(64'hD000));
    @(negedge clk);
    reset_n = 1'b0;
    ip.enable = 1'b0;
    #1;
    chk_all("rst_async", 0, 0, 0, 0, 0, Z, Z);
    @(posedge clk);
    drive(0, 1, 'hE000, 0, 0, 0, Z, 0);
    chk("post_rst.mem_enable", 512'(mp.enable), 512'(1'b1));
    chk("post_rst.mem_addr",   512'(mp.addr),   512'(64'hE000));
    drive(0, 0, 0, 0, 0, 0, Z, 0);
    drive(0, 0, 0, 0, 0, 1, l12, 0);
    chk_all("post_rst_done", 0, 'hE000, 1, 0, 0, l12, Z);

    // Repeat request to the last line
    drive(0, 1, 'h2000, 0, 0, 0, Z, 0);
    chk("rep_first.mem_enable", 512'(mp.enable), 512'(1'b1));
    drive(0, 0, 0, 0, 0, 1, l13, 0);
    chk_all("rep_first_done", 0, 'h2000, 1, 0, 0, l13, Z);
`ifdef LINE_ARB_REUSE_EN
    drive(0, 0, 0, 1, 'h2010, 0, Z, 0);
    chk_all("reuse_hit", 0, 'h2000, 0, 1, 0, l13, l13);
    drive(0, 0, 0, 0, 0, 0, Z, 1);
    chk_all("inv_pulse", 0, 'h2000, 0, 0, 0, l13, l13);
    drive(0, 0, 0, 1, 'h2010, 0, Z, 0);
    chk_all("after_inv_miss", 1, 'h2000, 0, 0, 0, l13, l13);
    drive(0, 0, 0, 0, 0, 1, l14, 0);
    chk_all("after_inv_done", 0, 'h2000, 0, 1, 0, l13, l14);
`else
    drive(0, 1, 'h2000, 0, 0, 0, Z, 0);
    chk_all("no_reuse_repeat", 1, 'h2000, 0, 0, 0, l13, Z);
    drive(0, 0, 0, 0, 0, 1, l14, 0);
    chk_all("no_reuse_done", 0, 'h2000, 1, 0, 0, l14, Z);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
